sda_byte_master: RTL and testbench



---
 rtl/sda_byte_master.sv | 152 +++++++++++++++
 tb/tb_sda_byte_master.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sda_byte_master.sv
// sda_byte_master: upstream master for the single-wire bidirectional sda link.
// Takes one byte command at a time, shifts it out MSB-first on sda with oe high,
// and for reads releases the line for TURN_CYCLES before clocking 8 bits back in.
// Each command yields exactly one response on the rsp_* valid/ready handshake.
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_data, cmd_rd      byte to send; 1 = read a byte back afterwards
//   rsp_valid/rsp_ready   response handshake (valid held until accepted)
//   rsp_data, rsp_rd      received byte (8'h00 for writes), echo of cmd_rd
//   sda                   serial data line, driven only while oe=1
//   oe                    sda output enable, also seen by the line device
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready=1
// TX     | shifting the command byte out, oe=1
// TURN   | line released, no one drives sda
// RX     | sampling 8 bits from the line device
// RESP   | response held on rsp_* until rsp_ready
module sda_byte_master #(
  parameter int BIT_DIV     = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_rd,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_rd,
  inout  wire        sda,
  output logic       oe
);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_TURN, S_RX, S_RESP} state_t;

  localparam int CW = 16;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] div_q, div_d;
  logic          rd_q, rd_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_rd_q, rsp_rd_d;
  logic [7:0]    rx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'h00;
      bit_q      <= 3'd0;
      div_q      <= '0;
      rd_q       <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      rd_q       <= rd_d;
      rsp_data_q <= rsp_data_d;
      rsp_rd_q   <= rsp_rd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    div_d      = div_q;
    rd_d       = rd_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d   = rsp_rd_q;
    rx_shift   = {shift_q[6:0], sda};

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          shift_d = cmd_data;
          rd_d    = cmd_rd;
          bit_d   = 3'd0;
          div_d   = '0;
          state_d = S_TX;
        end
      end
      S_TX: begin
        if (div_q == CW'(BIT_DIV - 1)) begin
          div_d   = '0;
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (rd_q) begin
              state_d = S_TURN;
            end else begin
              state_d    = S_RESP;
              rsp_data_d = 8'h00;
              rsp_rd_d   = 1'b0;
            end
          end
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      S_TURN: begin
        if (div_q == CW'(TURN_CYCLES - 1)) begin
          div_d   = '0;
          state_d = S_RX;
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      S_RX: begin
        if (div_q == CW'(BIT_DIV / 2)) begin
          shift_d = rx_shift;
        end
        if (div_q == CW'(BIT_DIV - 1)) begin
          div_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_RESP;
            // With BIT_DIV=2 the last sample and the bit end share a cycle.
            rsp_data_d = (div_q == CW'(BIT_DIV / 2)) ? rx_shift : shift_q;
            rsp_rd_d   = 1'b1;
          end
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state flop so reset releases sda at once.
  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign oe        = (state_q == S_TX);
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;
  assign sda       = oe ? shift_q[7] : 1'bz;

endmodule

// File: tb/tb_sda_byte_master.sv
module tb_sda_byte_master;
  localparam int BD = 4;
  localparam int TC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rd = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_ready = 1'b0;
  logic       dev_oe = 1'b0;
  logic       dev_bit = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_rd, oe;
  logic [7:0] rsp_data;
  wire        sda;

  int checks = 0;
  int errors = 0;

  assign sda = dev_oe ? dev_bit : 1'bz;

  sda_byte_master #(.BIT_DIV(BD), .TURN_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_rd(cmd_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .sda(sda), .oe(oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Issues one command, checks every cycle up to the response, optionally
  // stalls rsp_ready for bp cycles and optionally pokes cmd_valid mid-TX.
  task automatic run_cmd(input logic [7:0] d, input logic rd, input logic [7:0] dev,
                         input int bp, input logic poke);
    int tx_end;
    int rx_start;
    int total;
    logic [7:0] exp_data;
    tx_end   = 8 * BD;
    rx_start = 8 * BD + TC + 1;
    total    = rd ? (16 * BD + TC) : (8 * BD);
    exp_data = rd ? dev : 8'h00;
    chk("idle_ready", cmd_ready, 1);
    cmd_data  = d;
    cmd_rd    = rd;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    for (int i = 1; i <= total + 1; i++) begin
      @(negedge clk);
      if (i <= tx_end) begin
        chk("tx_oe", oe, 1);
        chk("tx_sda", sda, d[7 - (i - 1) / BD]);
      end else begin
        chk("idle_oe", oe, 0);
      end
      chk("rsp_valid_timing", rsp_valid, (i == total + 1) ? 1 : 0);
      chk("busy_ready", cmd_ready, 0);
      if (poke && i == 10) begin
        cmd_valid = 1'b1;
        cmd_data  = 8'hFF;
      end
      if (poke && i == 11) begin
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
      end
      if (rd && i >= rx_start && i <= total) begin
        dev_oe  = 1'b1;
        dev_bit = dev[7 - (i - rx_start) / BD];
      end else begin
        dev_oe  = 1'b0;
      end
    end
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_rd", rsp_rd, rd);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, exp_data);
      chk("bp_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_ready", cmd_ready, 1);
    chk("post_hs_valid", rsp_valid, 0);
  endtask

  initial begin
    logic [7:0] first_b;
    logic [7:0] second_b;
    logic oe_exp;
    logic [7:0] sda_exp;

    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 8'h00);
    chk("rst_rd", rsp_rd, 0);
    chk("rst_oe", oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(8'hA5, 1'b0, 8'h00, 0, 1'b0);
    run_cmd(8'h5A, 1'b1, 8'h3C, 0, 1'b0);
    run_cmd(8'h96, 1'b0, 8'h00, 5, 1'b0);
    run_cmd(8'hC3, 1'b1, 8'hE7, 5, 1'b0);
    run_cmd(8'h0F, 1'b0, 8'h00, 0, 1'b1);

    // Reset in the middle of bit 3 of a write.
    cmd_data  = 8'hC3;
    cmd_rd    = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_oe", oe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_oe", oe, 0);
    chk("async_rst_ready", cmd_ready, 1);
    chk("async_rst_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", cmd_ready, 1);
    chk("rel_valid", rsp_valid, 0);
    chk("rel_oe", oe, 0);
    run_cmd(8'h81, 1'b0, 8'h00, 0, 1'b0);

    // Back-to-back writes with rsp_ready held high and cmd_valid held.
    first_b   = 8'h01;
    second_b  = 8'h80;
    cmd_data  = first_b;
    cmd_rd    = 1'b0;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_data = second_b;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      oe_exp  = ((i >= 1 && i <= 32) || (i >= 35 && i <= 66)) ? 1'b1 : 1'b0;
      chk("b2b_oe", oe, oe_exp);
      if (i >= 1 && i <= 32) begin
        sda_exp = {7'd0, first_b[7 - (i - 1) / BD]};
        chk("b2b_sda1", sda, sda_exp);
      end
      if (i >= 35 && i <= 66) begin
        sda_exp = {7'd0, second_b[7 - (i - 35) / BD]};
        chk("b2b_sda2", sda, sda_exp);
      end
      chk("b2b_valid", rsp_valid, (i == 33 || i == 67) ? 1 : 0);
      chk("b2b_ready", cmd_ready, (i == 34 || i >= 68) ? 1 : 0);
      if (i == 35) cmd_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    chk("b2b_rsp_data", rsp_data, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
